// File: rtl/cmac_dot_seq.sv
// Sequencer for one CMAC2 complex multiply-accumulate unit: computes S = sum a_k*b_k
// by streaming operand pairs in and driving the CMAC2 control pins cycle by cycle.
module cmac_dot_seq #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                norm,
  input  logic                op_valid,
  input  logic [2*DATA_W-1:0] op_a,
  input  logic [2*DATA_W-1:0] op_b,
  output logic                op_ready,
  output logic [2*DATA_W-1:0] cmac_A,
  output logic [2*DATA_W-1:0] cmac_B,
  output logic                cmac_acc,
  output logic                cmac_abs,
  output logic                cmac_acc_en,
  output logic                cmac_mult_en,
  input  logic [2*DATA_W-1:0] cmac_S,
  input  logic                cmac_ovf,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] res,
  output logic                res_ovf
);

  // Operand handshake: a pair transfers in any cycle with op_valid && op_ready.
  // op_ready depends only on state, never on op_valid; op_valid may stay high across cycles.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    MUL   = 3'd2,
    ADD   = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           state;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   cnt_inc;
  logic [LEN_W-1:0] len_q;
  logic             norm_q;
  logic             any_en;

  assign cmac_A  = op_a;
  assign cmac_B  = op_b;
  assign cnt_inc = cnt + CNT_ONE;
  assign any_en  = cmac_acc_en | cmac_mult_en;
  assign busy    = (state == FIRST) || (state == MUL) || (state == ADD);
  assign done    = (state == FIN);

  always_comb begin
    op_ready     = 1'b0;
    cmac_acc     = 1'b0;
    cmac_abs     = 1'b0;
    cmac_acc_en  = 1'b0;
    cmac_mult_en = 1'b0;
    case (state)
      FIRST: begin
        // The first product is written straight into the acc register.
        op_ready = 1'b1;
        if (op_valid) begin
          cmac_abs    = norm_q;
          cmac_acc_en = 1'b1;
        end
      end
      MUL: begin
        op_ready = 1'b1;
        if (op_valid) begin
          cmac_abs     = norm_q;
          cmac_mult_en = 1'b1;
        end
      end
      ADD: begin
        cmac_acc    = 1'b1;
        cmac_acc_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      norm_q  <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
    end else begin
      if (any_en)
        res_ovf <= res_ovf | cmac_ovf;
      case (state)
        IDLE: begin
          if (start) begin
            res_ovf <= 1'b0;
            if (len != '0) begin
              len_q  <= len;
              norm_q <= norm;
              cnt    <= '0;
              state  <= FIRST;
            end else begin
              res   <= '0;
              state <= FIN;
            end
          end
        end
        FIRST: begin
          if (op_valid) begin
            cnt <= cnt_inc;
            if (cnt_inc == {1'b0, len_q}) begin
              res   <= cmac_S;
              state <= FIN;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (op_valid) begin
            cnt   <= cnt_inc;
            state <= ADD;
          end
        end
        ADD: begin
          if (cnt == {1'b0, len_q}) begin
            res   <= cmac_S;
            state <= FIN;
          end else begin
            state <= MUL;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_dot_seq.sv
// Bench for cmac_dot_seq: a behavioural CMAC2 unit on the control pins, plus a
// plain-arithmetic dot-product reference for result, overflow and timing.
module tb_cmac_dot_seq;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 2 * DW;
  localparam logic signed [65:0] MAXV = 66'sd2147483647;
  localparam logic signed [65:0] MINV = -66'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          norm = 1'b0;
  logic          op_valid = 1'b0;
  logic [CW-1:0] op_a = '0, op_b = '0;
  logic          op_ready, cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en;
  logic [CW-1:0] cmac_A, cmac_B, cmac_S, res;
  logic          cmac_ovf, busy, done, res_ovf;

  int checks = 0;
  int errors = 0;

  cmac_dot_seq #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .norm(norm),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .cmac_A(cmac_A), .cmac_B(cmac_B), .cmac_acc(cmac_acc), .cmac_abs(cmac_abs),
    .cmac_acc_en(cmac_acc_en), .cmac_mult_en(cmac_mult_en),
    .cmac_S(cmac_S), .cmac_ovf(cmac_ovf),
    .busy(busy), .done(done), .res(res), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- complex arithmetic (returns {ovf, re, im}) ----------------
  function automatic logic signed [65:0] sx(input logic [DW-1:0] v);
    return {{(66-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [CW:0] fit2(input logic signed [65:0] re, input logic signed [65:0] im);
    logic o;
    o = (re > MAXV) || (re < MINV) || (im > MAXV) || (im < MINV);
    return {o, re[DW-1:0], im[DW-1:0]};
  endfunction

  function automatic logic [CW:0] cmul(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic cj);
    logic signed [65:0] ar, ai, br, bi;
    ar = sx(x[CW-1:DW]); ai = sx(x[DW-1:0]);
    br = sx(y[CW-1:DW]); bi = sx(y[DW-1:0]);
    if (cj) return fit2(ar * br + ai * bi, ai * br - ar * bi);
    return fit2(ar * br - ai * bi, ar * bi + ai * br);
  endfunction

  function automatic logic [CW:0] cadd(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return fit2(sx(x[CW-1:DW]) + sx(y[CW-1:DW]), sx(x[DW-1:0]) + sx(y[DW-1:0]));
  endfunction

  // ---------------- behavioural CMAC2 unit ----------------
  logic [CW-1:0] mult_reg, acc_reg;
  logic [CW:0]   cm_out;

  always_comb begin
    cm_out = cmac_acc ? cadd(mult_reg, acc_reg) : cmul(cmac_A, cmac_B, cmac_abs);
    cmac_S   = cm_out[CW-1:0];
    cmac_ovf = cm_out[CW];
  end

  always @(posedge clk) begin
    if (!rst) begin
      mult_reg <= '0;
      acc_reg  <= '0;
    end else begin
      if (cmac_mult_en) mult_reg <= cmac_S;
      if (cmac_acc_en)  acc_reg  <= cmac_S;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [CW-1:0] a_arr[256];
  logic [CW-1:0] b_arr[256];
  logic [3:0]    exp_q[$];

  function automatic logic [CW:0] ref_dot(input int n, input logic nrm);
    logic [CW:0] p, s;
    logic o;
    o = 1'b0;
    s = '0;
    for (int k = 0; k < n; k++) begin
      p = cmul(a_arr[k], b_arr[k], nrm);
      o |= p[CW];
      if (k == 0) s = p;
      else begin
        s = cadd(s[CW-1:0], p[CW-1:0]);
        o |= s[CW];
      end
    end
    return {o, s[CW-1:0]};
  endfunction

  // Expected {abs, acc, acc_en, mult_en} on every enabled cycle of a job.
  task automatic build_exp(input int n, input logic nrm);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (k == 0) exp_q.push_back({nrm, 1'b0, 1'b1, 1'b0});
      else begin
        exp_q.push_back({nrm, 1'b0, 1'b0, 1'b1});
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0});
      end
    end
  endtask

  function automatic logic [CW-1:0] rnd_word(input bit big);
    logic [DW-1:0] re, im;
    re = big ? DW'($urandom) : DW'($urandom_range(0, 4000)) - DW'(2000);
    im = big ? DW'($urandom) : DW'($urandom_range(0, 4000)) - DW'(2000);
    return {re, im};
  endfunction

  // ---------------- job driver / monitor ----------------
  int            done_cyc, log_err, viol, stall_left;
  logic [CW-1:0] got_res;
  logic          got_ovf, post_done, post_busy;

  task automatic run_job(input int n, input logic nrm, input int stall_idx, input int stall_n,
                         input int sp_cyc);
    int idx;
    logic [3:0] code;
    done_cyc = -1; log_err = 0; viol = 0; idx = 0; stall_left = stall_n;
    start = 1'b1; len = LW'(n); norm = nrm; op_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 4 * n + 40; t++) begin
      start = (t == sp_cyc);
      if (start) len = LW'(7);
      op_valid = 1'b0;
      if (idx < n) begin
        if (idx == stall_idx && stall_left > 0 && op_ready) stall_left--;
        else op_valid = 1'b1;
        op_a = a_arr[idx];
        op_b = b_arr[idx];
      end
      @(negedge clk);
      if (cmac_A !== op_a || cmac_B !== op_b) viol++;
      if (op_ready && !op_valid && (cmac_acc_en || cmac_mult_en)) viol++;
      if (done !== 1'b1 && busy !== 1'b1) viol++;
      if (done === 1'b1 && busy !== 1'b0) viol++;
      if (cmac_acc_en || cmac_mult_en) begin
        code = {cmac_abs, cmac_acc, cmac_acc_en, cmac_mult_en};
        if (exp_q.size() == 0) log_err++;
        else if (code !== exp_q.pop_front()) log_err++;
      end
      if (op_valid && op_ready) idx++;
      if (done === 1'b1) begin
        done_cyc = t;
        got_res = res;
        got_ovf = res_ovf;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        post_done = done;
        post_busy = busy;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    op_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({op_ready, cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en, busy, done, res_ovf} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {op_ready, cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en, busy, done, res_ovf});
    end
    checks++;
    if (res !== '0) begin errors++; $display("FAIL reset_res got=%h exp=0", res); end
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    a_arr[0] = {32'd3, 32'd0};
    b_arr[0] = {32'd2, 32'd0};
    build_exp(1, 1'b0);
    run_job(1, 1'b0, -1, 0, 0);
    checks++;
    if (done_cyc != 2) begin errors++; $display("FAIL single_done_cycle got=%0d exp=2", done_cyc); end
    checks++;
    if (got_res !== {32'd6, 32'd0}) begin errors++; $display("FAIL single_res got=%h exp=%h", got_res, {32'd6, 32'd0}); end
    checks++;
    if (got_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", got_ovf); end
    checks++;
    if (log_err != 0 || exp_q.size() != 0 || viol != 0) begin
      errors++; $display("FAIL single_ctrl log_err=%0d left=%0d viol=%0d exp=0,0,0", log_err, exp_q.size(), viol);
    end
    checks++;
    if (post_done !== 1'b0) begin errors++; $display("FAIL single_done_width got=%b exp=0", post_done); end
  endtask

  task automatic test_three();
    for (int k = 0; k < 3; k++) begin
      a_arr[k] = {32'd1, 32'd1};
      b_arr[k] = {32'd1, 32'hFFFF_FFFF};
    end
    build_exp(3, 1'b0);
    run_job(3, 1'b0, -1, 0, 3);
    checks++;
    if (done_cyc != 6) begin errors++; $display("FAIL three_done_cycle got=%0d exp=6", done_cyc); end
    checks++;
    if (got_res !== {32'd6, 32'd0}) begin errors++; $display("FAIL three_res got=%h exp=%h", got_res, {32'd6, 32'd0}); end
    checks++;
    if (log_err != 0 || exp_q.size() != 0 || viol != 0) begin
      errors++; $display("FAIL three_enable_seq log_err=%0d left=%0d viol=%0d exp=0,0,0", log_err, exp_q.size(), viol);
    end
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0) begin
      errors++; $display("FAIL three_after_done busy=%b done=%b exp=0,0", post_busy, post_done);
    end
  endtask

  task automatic test_stall();
    logic [CW:0] exp;
    for (int k = 0; k < 4; k++) begin a_arr[k] = rnd_word(0); b_arr[k] = rnd_word(0); end
    exp = ref_dot(4, 1'b0);
    build_exp(4, 1'b0);
    run_job(4, 1'b0, 2, 2, 0);
    checks++;
    if (done_cyc != 10) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=10", done_cyc); end
    checks++;
    if (got_res !== exp[CW-1:0]) begin errors++; $display("FAIL stall_res got=%h exp=%h", got_res, exp[CW-1:0]); end
    checks++;
    if (stall_left != 0 || viol != 0 || log_err != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_ctrl stall_left=%0d viol=%0d log_err=%0d left=%0d exp=0,0,0,0",
                         stall_left, viol, log_err, exp_q.size());
    end
  endtask

  task automatic test_zero();
    a_arr[0] = {32'd1, 32'd2}; b_arr[0] = {32'd3, 32'd4};
    a_arr[1] = {32'd5, 32'd6}; b_arr[1] = {32'd7, 32'd8};
    build_exp(2, 1'b0);
    run_job(2, 1'b0, -1, 0, 4);
    checks++;
    if (done_cyc != 4 || got_res === '0 || post_busy !== 1'b0) begin
      errors++; $display("FAIL zero_prejob done=%0d res=%h busy_after=%b exp=4,nonzero,0", done_cyc, got_res, post_busy);
    end
    build_exp(0, 1'b0);
    run_job(0, 1'b0, -1, 0, 0);
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
    checks++;
    if (got_res !== '0 || got_ovf !== 1'b0) begin
      errors++; $display("FAIL zero_res got=%h ovf=%b exp=0,0", got_res, got_ovf);
    end
    checks++;
    if (log_err != 0 || viol != 0) begin errors++; $display("FAIL zero_enables log_err=%0d viol=%0d exp=0,0", log_err, viol); end
  endtask

  task automatic test_overflow();
    logic [CW:0] exp;
    a_arr[0] = {32'd1, 32'd0};          b_arr[0] = {32'd1, 32'd0};
    a_arr[1] = {32'h7FFF_FFFF, 32'd0};  b_arr[1] = {32'd2, 32'd0};
    a_arr[2] = {32'd1, 32'd0};          b_arr[2] = {32'd1, 32'd0};
    exp = ref_dot(3, 1'b0);
    build_exp(3, 1'b0);
    run_job(3, 1'b0, -1, 0, 0);
    checks++;
    if (got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", got_ovf); end
    checks++;
    if (got_res !== exp[CW-1:0] || done_cyc != 6) begin
      errors++; $display("FAIL ovf_res got=%h cyc=%0d exp=%h,6", got_res, done_cyc, exp[CW-1:0]);
    end
    a_arr[0] = {32'd4, 32'd4}; b_arr[0] = {32'd2, 32'd0};
    build_exp(1, 1'b0);
    run_job(1, 1'b0, -1, 0, 0);
    checks++;
    if (got_ovf !== 1'b0 || got_res !== {32'd8, 32'd8}) begin
      errors++; $display("FAIL ovf_clear got_ovf=%b res=%h exp=0,%h", got_ovf, got_res, {32'd8, 32'd8});
    end
  endtask

  task automatic test_reset_mid();
    logic [CW:0] exp;
    logic dn;
    int t;
    for (int k = 0; k < 3; k++) begin a_arr[k] = {32'd5, 32'd0}; b_arr[k] = {32'd1, 32'd0}; end
    start = 1'b1; len = LW'(3); norm = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1; op_a = a_arr[0]; op_b = b_arr[0];
    t = 0;
    while (cmac_acc !== 1'b1 && t < 8) begin @(posedge clk); #1; t++; end
    checks++;
    if (cmac_acc !== 1'b1) begin errors++; $display("FAIL rstmid_reach_add got=%b exp=1", cmac_acc); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({op_ready, cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en, busy, done, res_ovf} !== 8'h00 || res !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs ctrl=%b res=%h exp=00000000,0",
               {op_ready, cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en, busy, done, res_ovf}, res);
    end
    dn = 1'b0;
    repeat (5) begin @(negedge clk); dn |= done; end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b exp=0", dn); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin a_arr[k] = rnd_word(0); b_arr[k] = rnd_word(0); end
    exp = ref_dot(2, 1'b0);
    build_exp(2, 1'b0);
    run_job(2, 1'b0, -1, 0, 0);
    checks++;
    if (got_res !== exp[CW-1:0] || done_cyc != 4 || got_ovf !== exp[CW]) begin
      errors++; $display("FAIL rstmid_fresh res=%h cyc=%0d ovf=%b exp=%h,4,%b",
                         got_res, done_cyc, got_ovf, exp[CW-1:0], exp[CW]);
    end
  endtask

  task automatic test_random();
    logic [CW:0] exp;
    int n, sidx, sn, exp_cyc;
    logic nrm;
    for (int j = 0; j < 11; j++) begin
      n    = (j == 10) ? 255 : $urandom_range(1, 12);
      nrm  = (j == 10) ? 1'b0 : 1'($urandom_range(0, 1));
      sidx = (j == 10) ? -1 : $urandom_range(0, n - 1);
      sn   = (j == 10) ? 0 : $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        a_arr[k] = rnd_word(j < 10 && $urandom_range(0, 3) == 0);
        b_arr[k] = rnd_word(j < 10 && $urandom_range(0, 3) == 0);
      end
      exp = ref_dot(n, nrm);
      exp_cyc = 2 * n + sn;
      build_exp(n, nrm);
      run_job(n, nrm, sidx, sn, 0);
      checks++;
      if (done_cyc != exp_cyc) begin errors++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", j, done_cyc, exp_cyc); end
      checks++;
      if (got_res !== exp[CW-1:0] || got_ovf !== exp[CW]) begin
        errors++; $display("FAIL rand%0d_res got=%h ovf=%b exp=%h,%b", j, got_res, got_ovf, exp[CW-1:0], exp[CW]);
      end
      checks++;
      if (log_err != 0 || exp_q.size() != 0 || viol != 0) begin
        errors++; $display("FAIL rand%0d_ctrl log_err=%0d left=%0d viol=%0d exp=0,0,0", j, log_err, exp_q.size(), viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_stall();
    test_zero();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
